// File: rtl/instr_prefetch_queue_pkg.sv
// Shared definitions for the instruction prefetch queue: data widths, the
// reset fetch address, the sequential PC step and the {pc, instr} entry type.
package instr_prefetch_queue_pkg;

  localparam int          INSTR_W       = 32;
  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  // One buffered fetch: the byte address and the word read from that address.
  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the two low address bits are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_prefetch_queue_fetch_fifo.sv
// Small circular FIFO of {pc, instr} entries. Flush empties it in one cycle
// and wins over a push or pop in the same cycle. dout is zero while empty.
module fetch_fifo
  import instr_prefetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array: written at the tail; never reset, occupancy lives in count_q.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop) count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Fetch stage: issues sequential word reads to a 1-cycle sync ROM, buffers
// the returned words in fetch_fifo and hands {instr, pc} to the core.
//
// Handshake: instr_valid/instr/instr_pc come straight from the queue head and
// do not depend on instr_ready; the head is consumed at a rising edge where
// instr_valid && instr_ready, and holds steady while instr_ready is low.
// A redirect flushes everything (including a pop in that cycle and the ROM
// word already in flight) and restarts fetch at the aligned redirect_pc.
module instr_prefetch_queue
  import instr_prefetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  parameter int          AW       = 9
) (
  input  logic               clk,
  input  logic               rst,
  output logic [AW-1:0]      rom_addr,
  input  logic [INSTR_W-1:0] rom_dout,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          req_pending;
  logic          issue;
  logic [CW:0]   inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  fifo_din;
  fetch_entry_t  fifo_dout;

  // Credit counts queued entries plus the word still coming from the ROM and
  // ignores a same-cycle pop, so a response always finds a free slot.
  assign inflight = (CW+1)'(fifo_count) + (CW+1)'(req_pending);
  assign issue    = !redirect_valid && !fifo_full && (inflight < (CW+1)'(DEPTH));
  assign rom_addr = fetch_pc[AW-1:0];

  // Fetch address and outstanding-request tracking; redirect has top priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      req_pending <= 1'b0;
      req_pc      <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= align_pc(redirect_pc);
      req_pending <= 1'b0;
    end else if (issue) begin
      req_pending <= 1'b1;
      req_pc      <= fetch_pc;
      fetch_pc    <= fetch_pc + PC_STEP;
    end else begin
      req_pending <= 1'b0;
    end
  end

  assign fifo_din = '{pc: req_pc, instr: rom_dout};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (req_pending),
    .pop   (instr_valid && instr_ready),
    .flush (redirect_valid),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_dout.instr;
  assign instr_pc    = fifo_dout.pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Bench for instr_prefetch_queue: cycle-exact vector table for the directed
// scenarios, hand-written async reset sequence, then a randomized run checked
// against an expected-PC stream model.
module tb_instr_prefetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 9;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_dout;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_ready;

  int errors = 0;
  int checks = 0;

  instr_prefetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  // ---------------- clock / reset / ROM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word at a byte address: recognisable tag plus word index.
  function automatic logic [31:0] tag(input logic [8:0] a);
    return 32'hC0DE_0000 | {25'b0, a[8:2]};
  endfunction

  always @(posedge clk) rom_dout <= tag(rom_addr);

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rpc);
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Holds reset for two cycles, checks the reset state, releases just after
  // a rising edge so the caller starts in cycle 0.
  task automatic do_reset();
    drive(1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    tick();
    check("reset_valid", {31'b0, instr_valid}, 32'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_pc", instr_pc, 32'h0);
    check("reset_rom_addr", {23'b0, rom_addr}, 32'h0);
    rst = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst_first;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [8:0]  erom;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rf, input logic rdy, input logic rv, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [8:0] erom);
    vec_t v;
    v.rst_first = rf; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.erom = erom;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard (random phase) ----------------
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  int          since_flush;

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic restart_model(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = {pc[31:2], 2'b00};
    since_flush = 0;
    refill();
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] head;
    logic [8:0]  diff;
    logic        rdy;
    logic        rv;

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    #2;

    // Test 1: free-running stream, ready always high.
    add(1, 1, 0, 0, 0, 32'h00, 9'h000);
    add(0, 1, 0, 0, 0, 32'h00, 9'h004);
    add(0, 1, 0, 0, 1, 32'h00, 9'h008);
    add(0, 1, 0, 0, 1, 32'h04, 9'h00C);
    add(0, 1, 0, 0, 1, 32'h08, 9'h010);
    add(0, 1, 0, 0, 1, 32'h0C, 9'h014);
    // Test 2: stall 10 cycles -> exactly 4 entries, fetch parks at 16.
    add(1, 0, 0, 0, 0, 32'h00, 9'h000);
    add(0, 0, 0, 0, 0, 32'h00, 9'h004);
    add(0, 0, 0, 0, 1, 32'h00, 9'h008);
    add(0, 0, 0, 0, 1, 32'h00, 9'h00C);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 1, 32'h00, 9'h010);
    add(0, 1, 0, 0, 1, 32'h00, 9'h010);
    add(0, 1, 0, 0, 1, 32'h04, 9'h010);
    add(0, 1, 0, 0, 1, 32'h08, 9'h014);
    add(0, 1, 0, 0, 1, 32'h0C, 9'h018);
    add(0, 1, 0, 0, 1, 32'h10, 9'h01C);
    add(0, 1, 0, 0, 1, 32'h14, 9'h020);
    // Test 3: redirect to 0x40 with 3 queued + 1 pending (pop in R ignored).
    add(1, 0, 0, 0, 0, 32'h00, 9'h000);
    add(0, 0, 0, 0, 0, 32'h00, 9'h004);
    add(0, 0, 0, 0, 1, 32'h00, 9'h008);
    add(0, 0, 0, 0, 1, 32'h00, 9'h00C);
    add(0, 1, 1, 32'h40, 1, 32'h00, 9'h010);
    add(0, 1, 0, 0, 0, 32'h00, 9'h040);
    add(0, 1, 0, 0, 0, 32'h00, 9'h044);
    add(0, 1, 0, 0, 1, 32'h40, 9'h048);
    add(0, 1, 0, 0, 1, 32'h44, 9'h04C);
    // Test 4: back-to-back redirects 0x1FE then 0x1FC; ROM address wraps.
    add(0, 1, 1, 32'h1FE, 1, 32'h48, 9'h050);
    add(0, 1, 1, 32'h1FC, 0, 32'h00, 9'h1FC);
    add(0, 1, 0, 0, 0, 32'h00, 9'h1FC);
    add(0, 1, 0, 0, 0, 32'h00, 9'h000);
    add(0, 1, 0, 0, 1, 32'h1FC, 9'h004);
    add(0, 1, 0, 0, 1, 32'h200, 9'h008);
    add(0, 1, 0, 0, 1, 32'h204, 9'h00C);

    foreach (vecs[i]) begin
      if (vecs[i].rst_first) do_reset();
      drive(vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].ev});
      check($sformatf("vec%0d_rom_addr", i), {23'b0, rom_addr}, {23'b0, vecs[i].erom});
      if (vecs[i].ev) begin
        check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].epc);
        check($sformatf("vec%0d_instr", i), instr, tag(vecs[i].epc[8:0]));
      end
      tick();
    end

    // Test 5: asynchronous reset between clock edges, mid-stream.
    do_reset();
    drive(1'b1, 1'b0, 32'h0);
    repeat (5) tick();
    check("async_pre_valid", {31'b0, instr_valid}, 32'h1);
    #3;
    rst = 1'b0;
    #1;
    check("async_valid", {31'b0, instr_valid}, 32'h0);
    check("async_rom_addr", {23'b0, rom_addr}, 32'h0);
    check("async_pc", instr_pc, 32'h0);
    check("async_instr", instr, 32'h0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("restart%0d_valid", c), {31'b0, instr_valid}, (c >= 2) ? 32'h1 : 32'h0);
      check($sformatf("restart%0d_rom_addr", c), {23'b0, rom_addr}, 32'(c * 4));
      if (c >= 2) check($sformatf("restart%0d_pc", c), instr_pc, 32'((c - 2) * 4));
      tick();
    end

    // Test 6: random ready and occasional redirects against the PC-stream model.
    do_reset();
    restart_model(32'h0);
    for (int n = 0; n < 500; n++) begin
      rdy = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 24) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = 32'h0000_01F0 | 32'($urandom_range(0, 15));
        1:       rpc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: rpc = $urandom;
      endcase
      drive(rdy, rv, rpc);
      @(negedge clk);
      head = exp_q[0];
      diff = rom_addr - head[8:0];
      checks++;
      if (diff[8:2] > 7'(DEPTH)) begin
        errors++;
        $display("FAIL occupancy: got %0d in flight expected at most %0d", diff[8:2], DEPTH);
      end
      if (since_flush >= 2) check("live_valid", {31'b0, instr_valid}, 32'h1);
      if (instr_valid && instr_ready) begin
        head = exp_q.pop_front();
        check("sb_pc", instr_pc, head);
        check("sb_instr", instr, tag(head[8:0]));
        refill();
      end
      if (rv) restart_model(rpc);
      else since_flush++;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
